sprite_mover: RTL
=================

Name: sprite_mover

Overview:
- Parametrised successor to the single-pixel VGA mover.
- Owns the position of one SPR_W x SPR_H solid-colour sprite and moves it one pixel per rate tick in any of 8 directions.
- Each move is an erase-then-redraw: black pixels over the old footprint, then colour pixels at the new position, streamed one pixel per cycle into the VGA adapter's plot interface.
- Screen-edge handling is selectable: clamp, wrap or bounce.

Parameters:
- XW, 8, width of x coordinate
- YW, 7, width of y coordinate
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPR_W, 4, sprite width (1..16, < SCREEN_W)
- SPR_H, 4, sprite height (1..16, < SCREEN_H)
- RATE, 833333, clk cycles per move tick (>= 2)
- BOUND_MODE, 0, edge behaviour: 0 clamp, 1 wrap, 2 bounce

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- load  in  1  load start position and colour
- x_in  in  XW  start x (top-left corner)
- y_in  in  YW  start y (top-left corner)
- color_in  in  3  sprite colour, sampled on load
- dir_in  in  4  {left, down, up, right}
- enable  in  1  allow movement on tick
- x_out  out  XW  plot x
- y_out  out  YW  plot y
- color_out  out  3  plot colour
- plot  out  1  VGA write enable
- busy  out  1  high while ERASE/MOVE/DRAW
- pos_x  out  XW  current sprite x
- pos_y  out  YW  current sprite y
- hit_edge  out  1  one-cycle pulse when a boundary rule fired

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State IDLE; pos_x, pos_y, x_out, y_out, color_out, plot, busy, hit_edge, tick counter and velocity all 0.
  - Reset mid-ERASE/DRAW aborts immediately, with no cleanup of partially drawn pixels.
- Limits: MAXX = SCREEN_W-SPR_W, MAXY = SCREEN_H-SPR_H.
  - On load, x_in > MAXX saturates to MAXX; likewise y.
- Tick counter:
  - Free-running 0..RATE-1; tick is high for the one cycle where count == RATE-1.
  - A tick outside WAIT is dropped, not queued.
- States:
  - IDLE: load -> latch pos and colour, vel <= dir_in -> DRAW.
  - WAIT:
    - load has priority over tick: latch new pos, colour and vel, erase the old footprint, then DRAW at the new position.
    - Else if tick && enable && effective dir != 0 -> ERASE.
  - ERASE: SPR_W*SPR_H cycles with plot=1, color_out=0, old footprint -> MOVE (skipped on the load path).
  - MOVE: one cycle, plot=0. Updates pos per the boundary rule and pulses hit_edge if any axis hit a boundary -> DRAW.
  - DRAW: SPR_W*SPR_H cycles with plot=1, color_out=latched colour -> WAIT.
- Pixel order: raster, column fastest.
  - x_out = pos_x+cx, y_out = pos_y+cy, with cx 0..SPR_W-1, cy 0..SPR_H-1.
  - x_out, y_out and plot are registered and valid in the same cycle.
- Effective direction:
  - Modes 0/1: dir_in sampled at the tick.
  - Opposing bits cancel per axis (left+right → no x motion). Both axes cancelled counts as dir 0, so no ERASE.
  - Diagonals move both axes in the same MOVE.
- Mode 0, clamp: a step beyond 0 or MAX* leaves that axis unchanged; hit_edge=1.
- Mode 1, wrap: +1 from MAX* -> 0 and -1 from 0 -> MAX*; hit_edge=1.
- Mode 2, bounce:
  - dir_in is ignored after load; the internal velocity (vx, vy in {-1,0,+1}) drives motion every tick while enable=1.
  - A step that would leave [0,MAX*] negates that component and moves one pixel the other way (e.g. x=MAXX, vx=+1 -> x=MAXX-1, vx=-1); hit_edge=1.
- busy: high in ERASE, MOVE and DRAW; load while busy is ignored.
- enable=0 freezes movement only; an in-progress ERASE/DRAW completes.

Test Plan:
- Reset, then load x=10, y=20, colour 3'b100 (SPR 4x4) -> 16 consecutive plot cycles covering (10..13, 20..23) in raster order, all colour 3'b100; busy high for those 16 cycles; pos=(10,20).
- RATE=4, dir_in=4'b0001, enable=1 -> 16 black plots at x 10..13, 1 MOVE cycle, then 16 colour plots at x 11..14; pos_x=11; hit_edge stays 0.
- BOUND_MODE=0, pos_x=156, dir right -> pos_x stays 156; hit_edge pulses once; erase/redraw still occurs at x 156..159.
- BOUND_MODE=1, pos=(156,0), dir 4'b0011 -> pos=(0,116); hit_edge=1.
- BOUND_MODE=2, load x=155 with dir right, 3 ticks -> pos_x sequence 156, 155, 154; hit_edge on the second tick only.
- dir_in=4'b1001 on tick -> no plot activity and pos unchanged. reset_n=0 on the 5th DRAW cycle -> plot=0 next cycle, state IDLE, pos=(0,0).

Source files
------------

// File: rtl/sprite_mover.sv
// Moves one SPR_W x SPR_H sprite a pixel per RATE tick; each move streams an erase then a redraw, one pixel/cycle.
// Plot outputs are registered; load is ignored while busy, and ticks outside WAIT are dropped.
module sprite_mover #(
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int SPR_W      = 4,
  parameter int SPR_H      = 4,
  parameter int RATE       = 833333,
  parameter int BOUND_MODE = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic [2:0]    color_in,
  input  logic [3:0]    dir_in,
  input  logic          enable,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [2:0]    color_out,
  output logic          plot,
  output logic          busy,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          hit_edge
);
  localparam logic [XW-1:0] MAXX     = XW'(SCREEN_W - SPR_W);
  localparam logic [YW-1:0] MAXY     = YW'(SCREEN_H - SPR_H);
  localparam logic [XW-1:0] ONE_X    = XW'(1);
  localparam logic [YW-1:0] ONE_Y    = YW'(1);
  localparam int            CW       = $clog2(RATE);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);
  localparam logic [3:0]    LAST_CX  = 4'(SPR_W - 1);
  localparam logic [3:0]    LAST_CY  = 4'(SPR_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERASE, S_MOVE, S_DRAW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    vel, step, eff, nvel;
  logic [2:0]    color;
  logic [XW-1:0] ex, lx, nx;
  logic [YW-1:0] ey, ly, ny;
  logic          reload, tick, moving, last_px, hit;
  logic [3:0]    cx, cy, ncx, ncy;

  always_comb begin
    tick    = (cnt == CNT_LAST);
    eff     = (BOUND_MODE == 2) ? vel : dir_in;
    moving  = (eff[0] ^ eff[3]) | (eff[1] ^ eff[2]);
    lx      = (x_in > MAXX) ? MAXX : x_in;
    ly      = (y_in > MAXY) ? MAXY : y_in;
    last_px = (cx == LAST_CX) && (cy == LAST_CY);
    if (cx == LAST_CX) begin
      ncx = 4'd0;
      ncy = cy + 4'd1;
    end else begin
      ncx = cx + 4'd1;
      ncy = cy;
    end
    // Step uses the direction captured at the tick; bits: {left, down, up, right}
    nx = pos_x; ny = pos_y; nvel = vel; hit = 1'b0;
    if (step[0] && !step[3]) begin
      if (pos_x == MAXX) begin
        hit = 1'b1;
        if (BOUND_MODE == 1) nx = '0;
        else if (BOUND_MODE == 2) begin nx = MAXX - ONE_X; nvel[0] = 1'b0; nvel[3] = 1'b1; end
      end else nx = pos_x + ONE_X;
    end else if (step[3] && !step[0]) begin
      if (pos_x == '0) begin
        hit = 1'b1;
        if (BOUND_MODE == 1) nx = MAXX;
        else if (BOUND_MODE == 2) begin nx = ONE_X; nvel[3] = 1'b0; nvel[0] = 1'b1; end
      end else nx = pos_x - ONE_X;
    end
    if (step[2] && !step[1]) begin
      if (pos_y == MAXY) begin
        hit = 1'b1;
        if (BOUND_MODE == 1) ny = '0;
        else if (BOUND_MODE == 2) begin ny = MAXY - ONE_Y; nvel[2] = 1'b0; nvel[1] = 1'b1; end
      end else ny = pos_y + ONE_Y;
    end else if (step[1] && !step[2]) begin
      if (pos_y == '0) begin
        hit = 1'b1;
        if (BOUND_MODE == 1) ny = MAXY;
        else if (BOUND_MODE == 2) begin ny = ONE_Y; nvel[1] = 1'b0; nvel[2] = 1'b1; end
      end else ny = pos_y - ONE_Y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;   cnt <= '0;      vel <= '0;    step <= '0;
      color <= '0;       ex <= '0;       ey <= '0;     reload <= 1'b0;
      cx <= '0;          cy <= '0;       pos_x <= '0;  pos_y <= '0;
      x_out <= '0;       y_out <= '0;    color_out <= '0;
      plot <= 1'b0;      busy <= 1'b0;   hit_edge <= 1'b0;
    end else begin
      hit_edge <= 1'b0;
      cnt      <= tick ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: if (load) begin
          pos_x <= lx; pos_y <= ly; color <= color_in; vel <= dir_in;
          cx <= '0; cy <= '0; x_out <= lx; y_out <= ly; color_out <= color_in;
          plot <= 1'b1; busy <= 1'b1; state <= S_DRAW;
        end
        S_WAIT: if (load) begin
          // Old footprint is remembered in ex/ey so it can be erased after pos jumps
          ex <= pos_x; ey <= pos_y; pos_x <= lx; pos_y <= ly;
          color <= color_in; vel <= dir_in; reload <= 1'b1;
          cx <= '0; cy <= '0; x_out <= pos_x; y_out <= pos_y; color_out <= '0;
          plot <= 1'b1; busy <= 1'b1; state <= S_ERASE;
        end else if (tick && enable && moving) begin
          ex <= pos_x; ey <= pos_y; step <= eff; reload <= 1'b0;
          cx <= '0; cy <= '0; x_out <= pos_x; y_out <= pos_y; color_out <= '0;
          plot <= 1'b1; busy <= 1'b1; state <= S_ERASE;
        end
        S_ERASE: if (last_px) begin
          cx <= '0; cy <= '0;
          if (reload) begin
            x_out <= pos_x; y_out <= pos_y; color_out <= color; state <= S_DRAW;
          end else begin
            plot <= 1'b0; state <= S_MOVE;
          end
        end else begin
          cx <= ncx; cy <= ncy;
          x_out <= ex + XW'(ncx); y_out <= ey + YW'(ncy);
        end
        S_MOVE: begin
          pos_x <= nx; pos_y <= ny; vel <= nvel; hit_edge <= hit;
          x_out <= nx; y_out <= ny; color_out <= color;
          plot <= 1'b1; state <= S_DRAW;
        end
        S_DRAW: if (last_px) begin
          cx <= '0; cy <= '0; plot <= 1'b0; busy <= 1'b0; state <= S_WAIT;
        end else begin
          cx <= ncx; cy <= ncy;
          x_out <= pos_x + XW'(ncx); y_out <= pos_y + YW'(ncy);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
